// File: rtl/pma_rx_comma_aligner.sv
// Bit-rate deserializer that locks 10-bit symbol boundaries onto K28.5 commas; 1-cycle output latency.
// No backpressure (streaming). Optional lock loss on repeated off-boundary commas: PMA_RX_LOCK_LOSS_EN.
module pma_rx_comma_aligner #(
    parameter int DATA_WIDTH   = 10,
    parameter int MISALIGN_MAX = 4
) (
    input  logic                  Bit_Rate_Clk,
    input  logic                  Rst,
    input  logic                  Ser_in,
    input  logic                  RxPolarity,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_valid,
    output logic                  K285,
    output logic                  Lock
);

    localparam logic [DATA_WIDTH-1:0] COMMA_N = DATA_WIDTH'(10'h17C);
    localparam logic [DATA_WIDTH-1:0] COMMA_P = DATA_WIDTH'(10'h283);
    localparam logic [3:0]            CNT_LAST = 4'(DATA_WIDTH - 1);

    // Only a 10-bit symbol and a non-zero misalign threshold make sense here.
    if (DATA_WIDTH != 10 || MISALIGN_MAX < 1) begin : g_bad_cfg
        $error("pma_rx_comma_aligner: unsupported DATA_WIDTH/MISALIGN_MAX");
    end

    typedef enum logic {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_win,   w_win_nxt;
    logic [DATA_WIDTH-1:0] r_dout,  w_dout_nxt;
    logic [3:0]            r_cnt,   w_cnt_nxt;
    logic                  r_vld,   w_vld_nxt;
    logic                  r_k,     w_k_nxt;
    logic                  r_lock,  w_lock_nxt;
    logic                  w_bit;
    logic                  w_match;
    logic                  w_bnd;

`ifdef PMA_RX_LOCK_LOSS_EN
    localparam int MW = $clog2(MISALIGN_MAX + 1);
    logic [MW-1:0] r_mis, w_mis_nxt;
`endif

    assign w_bit   = Ser_in ^ RxPolarity;
    assign w_match = (r_win == COMMA_N) || (r_win == COMMA_P);
    assign w_bnd   = (r_cnt == CNT_LAST);

    always_comb begin
        w_win_nxt   = {w_bit, r_win[DATA_WIDTH-1:1]};
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_vld_nxt   = 1'b0;
        w_k_nxt     = r_k;
        w_lock_nxt  = r_lock;
`ifdef PMA_RX_LOCK_LOSS_EN
        w_mis_nxt   = r_mis;
`endif
        case (r_state)
            SEARCH: begin
                w_lock_nxt = 1'b0;
                if (w_match) begin
                    w_dout_nxt  = r_win;
                    w_vld_nxt   = 1'b1;
                    w_k_nxt     = 1'b1;
                    w_lock_nxt  = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ALIGNED;
                end
            end
            ALIGNED: begin
                if (w_bnd) begin
                    w_dout_nxt = r_win;
                    w_vld_nxt  = 1'b1;
                    w_k_nxt    = w_match;
                    w_cnt_nxt  = 4'd0;
`ifdef PMA_RX_LOCK_LOSS_EN
                    if (w_match) begin
                        w_mis_nxt = '0;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
`ifdef PMA_RX_LOCK_LOSS_EN
                    // Reaching the threshold drops lock immediately; the counter never rests at MAX.
                    if (w_match) begin
                        if (r_mis == MW'(MISALIGN_MAX - 1)) begin
                            w_mis_nxt   = '0;
                            w_lock_nxt  = 1'b0;
                            w_state_nxt = SEARCH;
                        end else begin
                            w_mis_nxt = r_mis + MW'(1);
                        end
                    end
`endif
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge Bit_Rate_Clk) begin
        if (Rst) begin
            r_state <= SEARCH;
            r_win   <= '0;
            r_dout  <= '0;
            r_cnt   <= 4'd0;
            r_vld   <= 1'b0;
            r_k     <= 1'b0;
            r_lock  <= 1'b0;
`ifdef PMA_RX_LOCK_LOSS_EN
            r_mis   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_dout  <= w_dout_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vld   <= w_vld_nxt;
            r_k     <= w_k_nxt;
            r_lock  <= w_lock_nxt;
`ifdef PMA_RX_LOCK_LOSS_EN
            r_mis   <= w_mis_nxt;
`endif
        end
    end

    assign Data_out   = r_dout;
    assign Data_valid = r_vld;
    assign K285       = r_k;
    assign Lock       = r_lock;

endmodule

// File: tb/tb_pma_rx_comma_aligner.sv
// Directed bench for pma_rx_comma_aligner: reset, lock, polarity, symbol spacing, phase shift, mid-lock reset.
module tb_pma_rx_comma_aligner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser = 1'b0;
    logic       pol = 1'b0;
    logic [9:0] dout;
    logic       vld;
    logic       k285;
    logic       lock;

    int n_chk  = 0;
    int n_pass = 0;

    logic [9:0] tbl [4] = '{10'h0AA, 10'h155, 10'h0CC, 10'h333};

    pma_rx_comma_aligner #(.DATA_WIDTH(10), .MISALIGN_MAX(4)) dut (
        .Bit_Rate_Clk (clk),
        .Rst          (rst),
        .Ser_in       (ser),
        .RxPolarity   (pol),
        .Data_out     (dout),
        .Data_valid   (vld),
        .K285         (k285),
        .Lock         (lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // b is the recovered bit; the wire carries it inverted when pol is set.
    task automatic tick(input logic b);
        ser = b ^ pol;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick(1'($urandom_range(0, 1)));
        chk("rst_dout", 16'(dout), 16'h0);
        chk("rst_vld",  16'(vld),  16'h0);
        chk("rst_k",    16'(k285), 16'h0);
        chk("rst_lock", 16'(lock), 16'h0);
        rst = 1'b0;
    endtask

    task automatic send_prefix();
        logic [6:0] pre;
        pre = 7'b0100101;
        for (int i = 0; i < 7; i++) tick(pre[i]);
    endtask

    // On bit 0 the previous symbol must strobe out; bits 1..9 must be quiet.
    task automatic send_sym(input logic [9:0] s, input logic chk_on,
                            input logic [9:0] prev, input logic prev_k);
        for (int i = 0; i < 10; i++) begin
            tick(s[i]);
            if (chk_on) begin
                if (i == 0) begin
                    chk("sym_vld",  16'(vld),  16'h1);
                    chk("sym_dout", 16'(dout), 16'(prev));
                    chk("sym_k",    16'(k285), 16'(prev_k));
                    chk("sym_lock", 16'(lock), 16'h1);
                end else begin
                    chk("sym_gap", 16'(vld), 16'h0);
                end
            end
        end
    endtask

    task automatic run_basic(input logic p, input logic [9:0] comma);
        pol = p;
        do_reset();
        send_prefix();
        chk("pre_lock", 16'(lock), 16'h0);
        chk("pre_vld",  16'(vld),  16'h0);
        send_sym(comma, 1'b0, 10'h0, 1'b0);
        chk("comma_nolock", 16'(lock), 16'h0);
        send_sym(10'h0AA, 1'b1, comma, 1'b1);
        send_sym(10'h155, 1'b1, 10'h0AA, 1'b0);
    endtask

    initial begin
        logic       q [$];
        logic [9:0] cm;
        logic [9:0] dsym;
        logic       exp_v;
        logic       exp_l;

        // Reset with random serial input.
        do_reset();

        // Plain, inverted-with-polarity, and RD+ comma streams.
        run_basic(1'b0, 10'h17C);
        run_basic(1'b1, 10'h17C);
        run_basic(1'b1, 10'h283);

        // Twenty data symbols after lock: strobes exactly 10 edges apart.
        pol = 1'b0;
        do_reset();
        send_prefix();
        send_sym(10'h17C, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 0) send_sym(tbl[0], 1'b1, 10'h17C, 1'b1);
            else        send_sym(tbl[i % 4], 1'b1, tbl[(i - 1) % 4], 1'b0);
        end

        // Shift phase by 3 bits, then five commas and a data symbol.
        cm   = 10'h17C;
        dsym = 10'h0AA;
        q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0);
        for (int c = 0; c < 5; c++)
            for (int i = 0; i < 10; i++) q.push_back(cm[i]);
        for (int i = 0; i < 10; i++) q.push_back(dsym[i]);
        q.push_back(1'b0);
        for (int t = 1; t <= 64; t++) begin
            tick(q[t - 1]);
`ifdef PMA_RX_LOCK_LOSS_EN
            exp_v = (t <= 41 && (t % 10) == 1) || t == 54 || t == 64;
            exp_l = (t < 44) || (t >= 54);
`else
            exp_v = ((t % 10) == 1);
            exp_l = 1'b1;
`endif
            chk("sh_vld",  16'(vld),  16'(exp_v));
            chk("sh_lock", 16'(lock), 16'(exp_l));
            if (t == 1) begin
                chk("sh_last_dout", 16'(dout), 16'(tbl[3]));
                chk("sh_last_k",    16'(k285), 16'h0);
            end
`ifdef PMA_RX_LOCK_LOSS_EN
            if (t == 54) begin
                chk("relock_dout", 16'(dout), 16'h17C);
                chk("relock_k",    16'(k285), 16'h1);
            end
            if (t == 64) begin
                chk("relock_data", 16'(dout), 16'h0AA);
                chk("relock_dk",   16'(k285), 16'h0);
            end
`else
            if (exp_v && t > 1) chk("sh_k", 16'(k285), 16'h0);
`endif
        end

        // Reset pulsed while locked at cnt=5, then relock 12 bits later.
        do_reset();
        send_prefix();
        send_sym(10'h17C, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(dsym[i]);
            if (i == 0) chk("mid_strobe", 16'(vld), 16'h1);
        end
        rst = 1'b1;
        tick(dsym[6]);
        rst = 1'b0;
        chk("mid_rst_dout", 16'(dout), 16'h0);
        chk("mid_rst_vld",  16'(vld),  16'h0);
        chk("mid_rst_k",    16'(k285), 16'h0);
        chk("mid_rst_lock", 16'(lock), 16'h0);
        tick(1'b1);
        tick(1'b0);
        send_sym(10'h17C, 1'b0, 10'h0, 1'b0);
        chk("mid_prelock", 16'(lock), 16'h0);
        tick(1'b0);
        chk("mid_relock_vld",  16'(vld),  16'h1);
        chk("mid_relock_dout", 16'(dout), 16'h17C);
        chk("mid_relock_k",    16'(k285), 16'h1);
        chk("mid_relock_lock", 16'(lock), 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
